led_frame_loader: RTL and testbench

//  Wishbone master that takes a raster-order 24-bit RGB pixel stream and writes each pixel into the
//  LED matrix frame memory at word address BASE + row*COL + col, i.e. {half,row[2:0],col} for 32x16.

---
 rtl/led_frame_loader.sv | 204 ++++++++++++++++++++
 tb/tb_led_frame_loader.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_loader.sv
// led_frame_loader: Wishbone master that writes a raster-order RGB pixel stream into
// LED matrix frame memory at word address BASE + row*COL + col.
//
// Optional build macro: LED_GAMMA_EN
//   When defined, a registered stage ahead of the FIFO applies c -> (c*c+255)>>8 per channel.
//   When undefined, pixels pass through unmodified.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   pix_valid/ready     source handshake (ready = FIFO can accept)
//   pix_data            {R,G,B} 8 bits each
//   pix_sof             first pixel of a frame
//   bus_adr .. bus_stb  Wishbone master outputs (word address, data, byte selects, we, cyc, stb)
//   bus_ack             Wishbone slave acknowledge
//   frame_done          1-cycle pulse when the last pixel of a frame is acked
//   err_short           1-cycle pulse when a sof pixel starts before the previous frame completed
module led_frame_loader #(
  parameter int unsigned COL      = 32,
  parameter int unsigned ROW      = 16,
  parameter int unsigned AW       = 32,
  parameter int unsigned BASE     = 0,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned IDLE_GAP = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic [23:0]   pix_data,
  input  logic          pix_sof,
  output logic [AW-1:0] bus_adr,
  output logic [31:0]   bus_dat,
  output logic [3:0]    bus_sel,
  output logic          bus_we,
  output logic          bus_cyc,
  output logic          bus_stb,
  input  logic          bus_ack,
  output logic          frame_done,
  output logic          err_short
);

  localparam int unsigned NPIX   = COL * ROW;
  localparam int unsigned ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned GAP_W  = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;

  typedef struct packed {
    logic        sof;
    logic [23:0] data;
  } pix_ent_t;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  wr_addr;
  logic [GAP_W-1:0]   gap_cnt;

  pix_ent_t           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  pix_ent_t           head;
  logic               full;
  logic               empty;
  logic               pop;
  logic               push;
  logic               push_valid;
  pix_ent_t           push_ent;
  logic               ready_next;

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign pop   = (state == S_WRITE) && bus_ack;
  // A full FIFO can still take an entry in the cycle its head is popped.
  assign push  = push_valid && (!full || pop);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

`ifdef LED_GAMMA_EN
  logic     in_fire;
  logic     stg_valid;
  logic     stg_valid_next;
  pix_ent_t stg_ent;

  function automatic logic [7:0] gamma(input logic [7:0] c);
    return 8'((16'(c) * 16'(c) + 16'd255) >> 8);
  endfunction

  assign in_fire        = pix_valid && pix_ready;
  assign push_valid     = stg_valid;
  assign push_ent       = stg_ent;
  assign stg_valid_next = in_fire || (stg_valid && !push);
  // The stage acts as one extra slot: stall only when both it and the FIFO are occupied.
  assign ready_next     = !((count_next == CNT_W'(DEPTH)) && stg_valid_next);

  // Gamma stage register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stg_valid <= 1'b0;
      stg_ent   <= '0;
    end else begin
      stg_valid <= stg_valid_next;
      if (in_fire) begin
        stg_ent <= '{sof: pix_sof,
                     data: {gamma(pix_data[23:16]), gamma(pix_data[15:8]), gamma(pix_data[7:0])}};
      end
    end
  end
`else
  assign push_valid = pix_valid && pix_ready;
  assign push_ent   = '{sof: pix_sof, data: pix_data};
  assign ready_next = (count_next != CNT_W'(DEPTH));
`endif

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= push_ent;
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pix_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_next;
      pix_ready <= ready_next;
    end
  end

  // Write sequencer: one bus write in flight, followed by a quiet gap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      bus_cyc    <= 1'b0;
      bus_stb    <= 1'b0;
      bus_we     <= 1'b0;
      bus_adr    <= '0;
      bus_dat    <= '0;
      bus_sel    <= '0;
      wr_addr    <= '0;
      gap_cnt    <= '0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            state   <= S_WRITE;
            bus_cyc <= 1'b1;
            bus_stb <= 1'b1;
            bus_we  <= 1'b1;
            bus_sel <= 4'b0111;
            bus_dat <= {8'h00, head.data};
            // sof restarts the frame; flag it if the previous frame was incomplete.
            if (head.sof) begin
              wr_addr   <= '0;
              bus_adr   <= AW'(BASE);
              err_short <= (wr_addr != '0);
            end else begin
              bus_adr   <= AW'(BASE) + AW'(wr_addr);
            end
          end
        end
        S_WRITE: begin
          if (bus_ack) begin
            bus_cyc    <= 1'b0;
            bus_stb    <= 1'b0;
            bus_we     <= 1'b0;
            frame_done <= (wr_addr == ADDR_W'(NPIX - 1));
            wr_addr    <= (wr_addr == ADDR_W'(NPIX - 1)) ? '0 : wr_addr + ADDR_W'(1);
            if (IDLE_GAP == 0) begin
              state <= S_IDLE;
            end else begin
              state   <= S_GAP;
              gap_cnt <= GAP_W'(IDLE_GAP);
            end
          end
        end
        S_GAP: begin
          // Late acks from the slave land here and are ignored.
          if (gap_cnt <= GAP_W'(1)) begin
            gap_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_loader.sv
// Testbench for led_frame_loader: a Wishbone slave model with programmable ack latency and
// ack hold time records every accepted write; a behavioural frame model predicts the
// address/data sequence and the frame_done / err_short pulses.
module tb_led_frame_loader;

  localparam int unsigned COL   = 32;
  localparam int unsigned ROW   = 16;
  localparam int unsigned NPIX  = COL * ROW;
  localparam int unsigned AW    = 32;
  localparam int unsigned BASE  = 0;
  localparam int unsigned DEPTH = 4;
`ifdef LED_GAMMA_EN
  localparam int unsigned PIPE_EXTRA = 1;
  localparam logic [31:0] GAMMA_EXP  = 32'h00FF4001;
`else
  localparam int unsigned PIPE_EXTRA = 0;
  localparam logic [31:0] GAMMA_EXP  = 32'h00FF8010;
`endif

  logic          clk;
  logic          rst;
  logic          pix_valid;
  logic          pix_ready;
  logic [23:0]   pix_data;
  logic          pix_sof;
  logic [AW-1:0] bus_adr;
  logic [31:0]   bus_dat;
  logic [3:0]    bus_sel;
  logic          bus_we;
  logic          bus_cyc;
  logic          bus_stb;
  logic          bus_ack;
  logic          frame_done;
  logic          err_short;

  led_frame_loader #(
    .COL(COL), .ROW(ROW), .AW(AW), .BASE(BASE), .DEPTH(DEPTH), .IDLE_GAP(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
    .bus_adr(bus_adr), .bus_dat(bus_dat), .bus_sel(bus_sel), .bus_we(bus_we),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_ack(bus_ack),
    .frame_done(frame_done), .err_short(err_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          we;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  m_addr;
  int  exp_err, exp_fd, obs_err, obs_fd, fd_at;
  int  checks = 0;
  int  errors = 0;
  int  ack_delay = 2;
  int  ack_hold  = 0;
  int  ack_cnt, hold_cnt;

  // Reference gamma: plain integer arithmetic on the channel value.
  function automatic logic [7:0] ref_gamma(input logic [7:0] c);
`ifdef LED_GAMMA_EN
    int v;
    v = int'(c);
    return 8'((v * v + 255) / 256);
`else
    return c;
`endif
  endfunction

  // Frame model: pixel k of a frame lands at BASE+k; the last one ends the frame.
  function automatic void model_push(input logic sof, input logic [23:0] d);
    wr_t w;
    if (sof) begin
      if (m_addr != 0) exp_err++;
      m_addr = 0;
    end
    w.adr = AW'(BASE + m_addr);
    w.dat = {8'h00, ref_gamma(d[23:16]), ref_gamma(d[15:8]), ref_gamma(d[7:0])};
    w.sel = 4'b0111;
    w.we  = 1'b1;
    exp_q.push_back(w);
    if (m_addr == int'(NPIX) - 1) begin
      exp_fd++;
      m_addr = 0;
    end else begin
      m_addr++;
    end
  endfunction

  function automatic void clear_sb();
    exp_q.delete();
    obs_q.delete();
    exp_err = 0; exp_fd = 0; obs_err = 0; obs_fd = 0; fd_at = -1;
  endfunction

  // Slave model and pulse monitor, evaluated on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      bus_ack  = 1'b0;
      ack_cnt  = 0;
      hold_cnt = 0;
    end else begin
      if (frame_done) begin
        obs_fd++;
        fd_at = obs_q.size();
      end
      if (err_short) obs_err++;
      if (bus_ack) begin
        if (hold_cnt > 0) hold_cnt--;
        else bus_ack = 1'b0;
      end else if (bus_cyc && bus_stb) begin
        ack_cnt++;
        if (ack_cnt >= ack_delay) begin
          bus_ack  = 1'b1;
          ack_cnt  = 0;
          hold_cnt = ack_hold;
          obs_q.push_back('{adr: bus_adr, dat: bus_dat, sel: bus_sel, we: bus_we});
        end
      end
    end
  end

  task automatic send(input logic sof, input logic [23:0] d, output bit stalled);
    int n = 0;
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = d;
    stalled   = !pix_ready;
    while (!pix_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!pix_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: pix_ready stayed 0 for %0d cycles, required 1", n);
    end else begin
      model_push(sof, d);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (obs_q.size() < exp_q.size()) begin
      errors++;
      $display("FAIL drain_timeout: writes seen %0d, required %0d", obs_q.size(), exp_q.size());
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_addr = 0;
    clear_sb();
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit st;
    int n = 0;
    rst = 1'b1;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    m_addr = 0;
    clear_sb();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_cyc, bus_stb, bus_we, pix_ready, frame_done, err_short} !== 6'b000100 ||
        bus_adr !== '0 || bus_dat !== '0 || bus_sel !== '0) begin
      errors++;
      $display("FAIL reset_state: cyc/stb/we/rdy/fd/err=%b adr=%h dat=%h sel=%b, required 000100 0 0 0",
               {bus_cyc, bus_stb, bus_we, pix_ready, frame_done, err_short}, bus_adr, bus_dat, bus_sel);
    end
    rst = 1'b0;
    @(negedge clk);
    // Start a write that the slave will not ack for a long time, then reset mid-transfer.
    ack_delay = 100;
    send(1'b0, 24'($urandom), st);
    send(1'b0, 24'($urandom), st);
    while (!bus_cyc && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus_cyc !== 1'b0 || bus_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_midwrite: cyc=%b stb=%b, required 0 0", bus_cyc, bus_stb);
    end
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: pix_ready=%b, required 1", pix_ready);
    end
    rst = 1'b0;
    m_addr = 0;
    clear_sb();
    ack_delay = 2;
    @(negedge clk);
    send(1'b0, 24'($urandom), st);
    wait_drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].adr !== AW'(BASE) || obs_q[0].dat !== exp_q[0].dat) begin
      errors++;
      $display("FAIL reset_next_addr: writes=%0d adr=%h dat=%h, required 1 %h %h",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0].adr : '1,
               obs_q.size() > 0 ? obs_q[0].dat : '1, AW'(BASE), exp_q[0].dat);
    end
  endtask

  task automatic test_frame();
    bit st;
    pulse_reset();
    ack_delay = 2; ack_hold = 0;
    for (int i = 0; i < int'(NPIX); i++) send(i == 0, 24'(i), st);
    wait_drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL frame_count: writes=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].adr !== exp_q[i].adr || obs_q[i].dat !== exp_q[i].dat ||
          obs_q[i].sel !== 4'b0111 || obs_q[i].we !== 1'b1) begin
        errors++;
        $display("FAIL frame_write[%0d]: adr=%h dat=%h sel=%b we=%b, required %h %h 0111 1",
                 i, obs_q[i].adr, obs_q[i].dat, obs_q[i].sel, obs_q[i].we, exp_q[i].adr, exp_q[i].dat);
      end
    end
    checks++;
    if (obs_fd !== 1 || fd_at !== int'(NPIX)) begin
      errors++;
      $display("FAIL frame_done: pulses=%0d at write %0d, required 1 at %0d", obs_fd, fd_at, NPIX);
    end
    checks++;
    if (obs_err !== 0) begin
      errors++;
      $display("FAIL frame_err_short: pulses=%0d, required 0", obs_err);
    end
    clear_sb();
  endtask

  task automatic test_short_frame();
    bit st;
    ack_delay = 1; ack_hold = 0;
    for (int i = 0; i < 10; i++) send(i == 0, 24'($urandom), st);
    send(1'b1, 24'($urandom), st);
    send(1'b0, 24'($urandom), st);
    wait_drain();
    checks++;
    if (obs_q.size() != 12 || obs_q[10].adr !== AW'(BASE) || obs_q[11].adr !== AW'(BASE + 1)) begin
      errors++;
      $display("FAIL short_restart_addr: writes=%0d adr10=%h adr11=%h, required 12 %h %h",
               obs_q.size(), obs_q.size() > 10 ? obs_q[10].adr : '1,
               obs_q.size() > 11 ? obs_q[11].adr : '1, AW'(BASE), AW'(BASE + 1));
    end
    checks++;
    if (obs_err !== 1 || exp_err !== 1) begin
      errors++;
      $display("FAIL short_err_short: pulses=%0d, required 1", obs_err);
    end
    checks++;
    if (obs_fd !== 0) begin
      errors++;
      $display("FAIL short_frame_done: pulses=%0d, required 0", obs_fd);
    end
    clear_sb();
  endtask

  task automatic test_backpressure();
    bit st;
    int first_stall = -1;
    ack_delay = 20; ack_hold = 0;
    for (int i = 0; i < 12; i++) begin
      send(1'b0, 24'($urandom), st);
      if (st && first_stall < 0) first_stall = i;
    end
    wait_drain();
    checks++;
    if (first_stall != int'(DEPTH + PIPE_EXTRA)) begin
      errors++;
      $display("FAIL bp_ready_low: first stall after %0d pushes, required %0d",
               first_stall, DEPTH + PIPE_EXTRA);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count: writes=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].adr !== exp_q[i].adr || obs_q[i].dat !== exp_q[i].dat) begin
        errors++;
        $display("FAIL bp_write[%0d]: adr=%h dat=%h, required %h %h",
                 i, obs_q[i].adr, obs_q[i].dat, exp_q[i].adr, exp_q[i].dat);
      end
    end
    clear_sb();
  endtask

  task automatic test_stale_ack();
    bit st;
    int a0 = m_addr;
    ack_delay = 1; ack_hold = 2;
    for (int i = 0; i < 20; i++) send(1'b0, 24'($urandom), st);
    wait_drain();
    ack_hold = 0;
    checks++;
    if (obs_q.size() != 20 || m_addr != a0 + 20) begin
      errors++;
      $display("FAIL stale_count: writes=%0d, required 20", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].adr !== exp_q[i].adr || obs_q[i].dat !== exp_q[i].dat) begin
        errors++;
        $display("FAIL stale_write[%0d]: adr=%h dat=%h, required %h %h",
                 i, obs_q[i].adr, obs_q[i].dat, exp_q[i].adr, exp_q[i].dat);
      end
    end
    clear_sb();
  endtask

  task automatic test_gamma();
    bit st;
    ack_delay = 2; ack_hold = 0;
    send(1'b0, 24'hFF8010, st);
    wait_drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].dat !== GAMMA_EXP) begin
      errors++;
      $display("FAIL gamma_pixel: writes=%0d dat=%h, required 1 %h",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0].dat : '1, GAMMA_EXP);
    end
    clear_sb();
  endtask

  task automatic test_random();
    bit st;
    for (int r = 0; r < 3; r++) begin
      ack_delay = int'($urandom_range(1, 4));
      for (int i = 0; i < 100; i++) begin
        send($urandom_range(0, 39) == 0, 24'($urandom), st);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    wait_drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: writes=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].adr !== exp_q[i].adr || obs_q[i].dat !== exp_q[i].dat ||
          obs_q[i].sel !== 4'b0111 || obs_q[i].we !== 1'b1) begin
        errors++;
        $display("FAIL rand_write[%0d]: adr=%h dat=%h sel=%b we=%b, required %h %h 0111 1",
                 i, obs_q[i].adr, obs_q[i].dat, obs_q[i].sel, obs_q[i].we, exp_q[i].adr, exp_q[i].dat);
      end
    end
    checks++;
    if (obs_err !== exp_err || obs_fd !== exp_fd) begin
      errors++;
      $display("FAIL rand_pulses: err_short=%0d frame_done=%0d, required %0d %0d",
               obs_err, obs_fd, exp_err, exp_fd);
    end
    clear_sb();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_short_frame();
    test_backpressure();
    test_stale_ack();
    test_gamma();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
